// File: rtl/led_pattern_seq.sv
// LED test pattern sequencer: samples the divided clock as data, turns its rising
// edges into ticks, prescales ticks into steps and drives walk/bounce/binary/blink.
module led_pattern_seq #(
   parameter int N_LED          = 8,
   parameter int TICKS_PER_STEP = 4
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             div_clk,
   input  logic             enable,
   input  logic [1:0]       mode,
   output logic [N_LED-1:0] leds,
   output logic             step,
   output logic [1:0]       mode_active
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam logic [1:0] MODE_WALK   = 2'd0;
   localparam logic [1:0] MODE_BOUNCE = 2'd1;
   localparam logic [1:0] MODE_BINARY = 2'd2;
   localparam logic [1:0] MODE_BLINK  = 2'd3;

   // A setting of 0 behaves exactly like 1: every tick is an advance.
   localparam logic [15:0] TCNT_LAST = (TICKS_PER_STEP <= 1) ? 16'd0 : 16'(TICKS_PER_STEP - 1);
   localparam logic [N_LED-1:0] LED_ONE  = N_LED'(1'b1);
   localparam logic [N_LED-1:0] LED_ZERO = '0;

   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic [15:0]      r_tcnt;
   dir_t             r_dir;

   logic             w_tick;
   logic             w_advance;
   logic [15:0]      w_tcnt_nxt;
   dir_t             w_dir_nxt;
   logic [N_LED-1:0] w_leds_nxt;
   logic [N_LED-1:0] w_rot;
   logic [1:0]       w_mode_nxt;
   logic             w_step_nxt;

   generate
      if (N_LED > 1) begin : g_rot
         assign w_rot = {leds[N_LED-2:0], leds[N_LED-1]};
      end else begin : g_rot_single
         assign w_rot = leds;
      end
   endgenerate

   // Three-flop sampler of div_clk; the third flop only serves edge detection.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= div_clk;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_tick    = r_s2 & ~r_s3;
   assign w_advance = w_tick & enable & (r_tcnt >= TCNT_LAST);

   // Prescaler, pattern and direction next-state; mode is only looked at on an advance.
   always_comb begin
      w_tcnt_nxt = r_tcnt;
      w_dir_nxt  = r_dir;
      w_leds_nxt = leds;
      w_mode_nxt = mode_active;
      w_step_nxt = 1'b0;
      if (w_advance) begin
         w_tcnt_nxt = 16'd0;
         w_step_nxt = 1'b1;
         if (mode != mode_active) begin
            w_mode_nxt = mode;
            w_dir_nxt  = DIR_UP;
            if ((mode == MODE_WALK) || (mode == MODE_BOUNCE)) begin
               w_leds_nxt = LED_ONE;
            end else begin
               w_leds_nxt = LED_ZERO;
            end
         end else begin
            case (mode_active)
               MODE_WALK:   w_leds_nxt = w_rot;
               MODE_BOUNCE: begin
                  if (N_LED == 1) begin
                     w_leds_nxt = leds;
                  end else begin
                     case (r_dir)
                        DIR_UP: begin
                           if (leds[N_LED-1]) begin
                              w_leds_nxt = leds >> 1;
                              w_dir_nxt  = DIR_DOWN;
                           end else begin
                              w_leds_nxt = leds << 1;
                           end
                        end
                        DIR_DOWN: begin
                           if (leds[0]) begin
                              w_leds_nxt = leds << 1;
                              w_dir_nxt  = DIR_UP;
                           end else begin
                              w_leds_nxt = leds >> 1;
                           end
                        end
                        default: w_leds_nxt = leds;
                     endcase
                  end
               end
               MODE_BINARY: w_leds_nxt = leds + LED_ONE;
               MODE_BLINK:  w_leds_nxt = ~leds;
               default:     w_leds_nxt = leds;
            endcase
         end
      end else if (w_tick && enable) begin
         w_tcnt_nxt = r_tcnt + 16'd1;
      end else begin
         w_tcnt_nxt = r_tcnt;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         r_tcnt      <= 16'd0;
         r_dir       <= DIR_UP;
         leds        <= LED_ONE;
         step        <= 1'b0;
         mode_active <= MODE_WALK;
      end else begin
         r_tcnt      <= w_tcnt_nxt;
         r_dir       <= w_dir_nxt;
         leds        <= w_leds_nxt;
         step        <= w_step_nxt;
         mode_active <= w_mode_nxt;
      end
   end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Consumes the slow divided clock from the clock divider and drives the board LEDs with selectable test patterns. div_clk is treated as data: it is synchronised into the system clock domain and edge-detected into single-cycle ticks. Ticks are prescaled into pattern steps. Sits directly downstream of the divider in the LED test design.

Parameters:
N_LED, 8, number of LED outputs (legal range ≥1).
TICKS_PER_STEP, 4, div_clk rising edges per pattern step (16-bit); 0 behaves as 1.

Ports:
clk  input  1  system clock (the same clock that feeds the divider)
rst_in  input  1  reset, asynchronous, active-high
div_clk  input  1  divided clock from the divider, sampled as data
enable  input  1  1 = run, 0 = freeze pattern and prescaler
mode  input  2  requested pattern: 0 walk, 1 bounce, 2 binary count, 3 blink
leds  output  N_LED  LED drive, registered
step  output  1  one-clk pulse on every pattern update
mode_active  output  2  pattern currently applied

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately with no clock edge. Reset values:
  - sync flops s1, s2, s3 = 0
  - tcnt = 0, dir = up
  - leds = 1 (bit 0 set, all other bits 0)
  - step = 0, mode_active = 0
- Synchroniser and edge detect:
  - s1 <= div_clk; s2 <= s1; s3 <= s2.
  - tick = s2 & ~s3 (combinational).
  - Latency: a div_clk rise first sampled at clk edge k gives tick high between edges k+1 and k+2.
  - Any leds/step update then registers at edge k+2.
- Input constraint: div_clk high and low phases must each last ≥2 clk cycles. A constant div_clk produces no ticks.
- Prescaler (tcnt, 16 bits) acts only on cycles with tick=1 and enable=1:
  - If tcnt ≥ TICKS_PER_STEP−1: tcnt <= 0 and an advance occurs.
  - Otherwise tcnt <= tcnt+1.
- enable=0: tcnt, leds, dir and mode_active hold; ticks are discarded; step=0.
- step is registered: 1 for exactly one clk after each advance, otherwise 0.
- On an advance where mode ≠ mode_active (mode is sampled only at advances):
  - mode_active <= mode; dir <= up.
  - leds loads the initial value of the new mode instead of stepping.
  - step still pulses.
- On an advance where mode = mode_active:
  - mode 0 walk: rotate left, leds <= {leds[N_LED−2:0], leds[N_LED−1]}. Initial value 1.
  - mode 1 bounce: single lit bit. Initial value 1.
    - dir up and leds[N_LED−1]=1: shift right, dir <= down.
    - dir up otherwise: shift left.
    - dir down and leds[0]=1: shift left, dir <= up.
    - dir down otherwise: shift right.
    - N_LED=4 sequence: 1,2,4,8,4,2,1,2,…
  - mode 2 binary: leds <= leds+1 modulo 2^N_LED, wrapping all-ones to 0. Initial value 0.
  - mode 3 blink: leds <= ~leds. Initial value 0.
  - N_LED=1: walk and bounce hold leds=1; binary and blink toggle.
- Reset asserted mid-step or mid-mode-change: all state returns to reset values immediately; the pending tick is lost.
- Reset deasserted: operation resumes at mode 0, leds=1, regardless of the mode input. A different mode is applied at the first advance.

Test Plan:
1. Assert rst_in between clk edges -> leds=0x01, step=0, mode_active=0 immediately. Release; hold div_clk static for 100 clk -> no change.
2. N_LED=8, TICKS_PER_STEP=4, mode=0, enable=1, div_clk period 20 clk -> after 4 rises leds=0x02 with a single 1-clk step pulse. After 32 rises leds=0x01 again. step occurs exactly 2 clk edges after the sampling edge of the 4th rise.
3. N_LED=4, TICKS_PER_STEP=1, mode=1 -> successive steps give leds 1,2,4,8,4,2,1,2.
4. TICKS_PER_STEP=4, mode=0; switch mode to 2 after 2 ticks -> at 4th tick leds=0x00, mode_active=2, step pulses; next step leds=0x01. Force a run to 0xFF -> next step 0x00.
5. enable=0 for 10 div_clk rises mid-window (tcnt=2) -> leds, tcnt and mode_active unchanged, step stays 0. Re-enable -> advance after 2 more rises.
6. TICKS_PER_STEP=0, mode=3 -> leds toggles 0x00/0xFF on every rise. Pulse rst_in while leds=0xFF -> leds=0x01, mode_active=0 immediately.
